// File: rtl/ec_fe12_pow_win_s_if.sv
// Streaming handshake bundle: val/rdy flow control with packet delimiters
// (sop/eop), a data word and a sideband control field.
interface ec_fe12_pow_win_s_if #(
    parameter int DAT_BITS = 8,
    parameter int CTL_BITS = 8
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport master (output val, sop, eop, dat, ctl, input rdy);
    modport slave  (input val, sop, eop, dat, ctl, output rdy);
endinterface

// File: rtl/ec_fe12_pow_win_s.sv
// Fixed-window exponentiation of a NUM_ELEM-word field element by the
// exponent carried in the input packet's ctl field. Odd and even powers
// base^1..base^(2^WIN-1) are precomputed into a table, leading zero windows
// are skipped, and each later window costs WIN squarings plus one optional
// table multiply. All arithmetic is delegated to an external multiplier
// with one request in flight at a time.
module ec_fe12_pow_win_s #(
    parameter type FE_TYPE      = logic [380:0],
    parameter int  NUM_ELEM     = 12,
    parameter int  POW_BITS     = 64,
    parameter int  CTL_BIT_POW  = 0,
    parameter int  WIN          = 4,
    parameter int  SQ_BIT       = 24,
    parameter int  MUL_CTL_BITS = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    ec_fe12_pow_win_s_if.slave    i_pow_if,
    ec_fe12_pow_win_s_if.master   o_pow_if,
    ec_fe12_pow_win_s_if.master   o_mul_if,
    ec_fe12_pow_win_s_if.slave    i_mul_if
);
    localparam int W        = $bits(FE_TYPE);
    localparam int PCTL     = CTL_BIT_POW + POW_BITS;
    localparam int TBL_N    = (2 ** WIN) - 1;
    localparam int NWIN     = (POW_BITS + WIN - 1) / WIN;
    localparam int EXP_W    = NWIN * WIN;
    localparam int IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int WI_W     = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_PRE, S_SCAN, S_COPY, S_SQR, S_MUL, S_OUT
    } state_t;

    // Sub-phase shared by every state that runs a multiplier transaction
    // (and reused by OUT to load its first beat).
    typedef enum logic [1:0] {M_START, M_SEND, M_RECV} mphase_t;

    state_t            state;
    mphase_t           mphase;
    logic [PCTL-1:0]   ctl_q;
    logic [IDX_W-1:0]  ld_idx;
    logic [IDX_W-1:0]  beat_idx;
    logic [IDX_W-1:0]  rsp_idx;
    logic [WIN-1:0]    pre_idx;
    logic [WI_W-1:0]   win_idx;
    logic [WIN-1:0]    win_sel;
    logic [2:0]        sq_cnt;

    // tbl[i] holds base^(i+1); acc is the running result.
    FE_TYPE tbl [TBL_N][NUM_ELEM];
    FE_TYPE acc [NUM_ELEM];

    logic [PCTL-1:0]   ctl_eff;
    logic [IDX_W-1:0]  ld_k;
    logic              in_exp_zero;
    logic [EXP_W-1:0]  exp_pad;
    logic [WIN-1:0]    cur_win;
    logic [IDX_W-1:0]  op_idx;
    FE_TYPE            op_a;
    FE_TYPE            op_b;
    logic              unused_sig;

    assign unused_sig = ^{1'b0, i_pow_if.eop, i_mul_if.sop, i_mul_if.eop, i_mul_if.ctl};

    // Decode the incoming beat, the current exponent window and the operand
    // words for whichever beat is about to be presented on a bus.
    always_comb begin
        ctl_eff     = i_pow_if.sop ? i_pow_if.ctl : ctl_q;
        ld_k        = i_pow_if.sop ? '0 : ld_idx;
        in_exp_zero = (ctl_eff[CTL_BIT_POW +: POW_BITS] == '0);
        exp_pad     = EXP_W'(ctl_q[CTL_BIT_POW +: POW_BITS]);
        cur_win     = exp_pad[win_idx * WIN +: WIN];
        op_idx      = (mphase == M_START) ? '0 : IDX_W'(beat_idx + 1'b1);
        op_a        = acc[op_idx];
        op_b        = acc[op_idx];
        case (state)
            S_PRE: begin
                op_a = tbl[pre_idx - WIN'(2)][op_idx];
                op_b = tbl[0][op_idx];
            end
            S_MUL: begin
                op_b = tbl[win_sel - 1'b1][op_idx];
            end
            default: ;
        endcase
    end

    // Main controller: load, precompute, window scan, square/multiply
    // scheduling and result streaming, with all bus outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            mphase        <= M_START;
            ctl_q         <= '0;
            ld_idx        <= '0;
            beat_idx      <= '0;
            rsp_idx       <= '0;
            pre_idx       <= '0;
            win_idx       <= '0;
            win_sel       <= '0;
            sq_cnt        <= '0;
            i_pow_if.rdy  <= 1'b0;
            i_mul_if.rdy  <= 1'b0;
            o_pow_if.val  <= 1'b0;
            o_pow_if.sop  <= 1'b0;
            o_pow_if.eop  <= 1'b0;
            o_pow_if.dat  <= '0;
            o_pow_if.ctl  <= '0;
            o_mul_if.val  <= 1'b0;
            o_mul_if.sop  <= 1'b0;
            o_mul_if.eop  <= 1'b0;
            o_mul_if.dat  <= '0;
            o_mul_if.ctl  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    i_pow_if.rdy <= 1'b1;
                    ld_idx       <= '0;
                    state        <= S_LOAD;
                end

                S_LOAD: begin
                    if (i_pow_if.val && i_pow_if.rdy) begin
                        tbl[0][ld_k] <= i_pow_if.dat;
                        if (i_pow_if.sop)
                            ctl_q <= i_pow_if.ctl;
                        if (ld_k == LAST_IDX) begin
                            i_pow_if.rdy <= 1'b0;
                            mphase       <= M_START;
                            if (in_exp_zero) begin
                                for (int j = 0; j < NUM_ELEM; j++)
                                    acc[j] <= '0;
                                acc[0] <= FE_TYPE'(1);
                                state  <= S_OUT;
                            end else if (TBL_N == 1) begin
                                win_idx <= WI_W'(NWIN - 1);
                                state   <= S_SCAN;
                            end else begin
                                pre_idx <= WIN'(2);
                                state   <= S_PRE;
                            end
                        end else begin
                            ld_idx <= IDX_W'(ld_k + 1'b1);
                        end
                    end
                end

                S_PRE, S_SQR, S_MUL: begin
                    case (mphase)
                        M_START: begin
                            o_mul_if.val <= 1'b1;
                            o_mul_if.sop <= 1'b1;
                            o_mul_if.eop <= (LAST_IDX == '0);
                            o_mul_if.dat <= {op_b, op_a};
                            o_mul_if.ctl <= (state == S_SQR) ? (MUL_CTL_BITS'(1) << SQ_BIT) : '0;
                            beat_idx     <= '0;
                            mphase       <= M_SEND;
                        end
                        M_SEND: begin
                            if (o_mul_if.val && o_mul_if.rdy) begin
                                if (beat_idx == LAST_IDX) begin
                                    o_mul_if.val <= 1'b0;
                                    o_mul_if.sop <= 1'b0;
                                    o_mul_if.eop <= 1'b0;
                                    i_mul_if.rdy <= 1'b1;
                                    rsp_idx      <= '0;
                                    mphase       <= M_RECV;
                                end else begin
                                    beat_idx     <= op_idx;
                                    o_mul_if.sop <= 1'b0;
                                    o_mul_if.eop <= (op_idx == LAST_IDX);
                                    o_mul_if.dat <= {op_b, op_a};
                                end
                            end
                        end
                        M_RECV: begin
                            if (i_mul_if.val && i_mul_if.rdy) begin
                                if (state == S_PRE)
                                    tbl[pre_idx - 1'b1][rsp_idx] <= i_mul_if.dat;
                                else
                                    acc[rsp_idx] <= i_mul_if.dat;
                                if (rsp_idx == LAST_IDX) begin
                                    i_mul_if.rdy <= 1'b0;
                                    mphase       <= M_START;
                                    if (state == S_PRE) begin
                                        if (pre_idx == WIN'(TBL_N)) begin
                                            win_idx <= WI_W'(NWIN - 1);
                                            state   <= S_SCAN;
                                        end else begin
                                            pre_idx <= pre_idx + 1'b1;
                                        end
                                    end else if (state == S_SQR && sq_cnt != 3'(WIN - 1)) begin
                                        sq_cnt <= sq_cnt + 1'b1;
                                    end else if (state == S_SQR && cur_win != '0) begin
                                        win_sel <= cur_win;
                                        state   <= S_MUL;
                                    end else if (win_idx == '0) begin
                                        state <= S_OUT;
                                    end else begin
                                        win_idx <= win_idx - 1'b1;
                                        sq_cnt  <= '0;
                                        state   <= S_SQR;
                                    end
                                end else begin
                                    rsp_idx <= rsp_idx + 1'b1;
                                end
                            end
                        end
                        default: mphase <= M_START;
                    endcase
                end

                S_SCAN: begin
                    if (cur_win == '0) begin
                        win_idx <= win_idx - 1'b1;
                    end else begin
                        win_sel  <= cur_win;
                        beat_idx <= '0;
                        state    <= S_COPY;
                    end
                end

                S_COPY: begin
                    acc[beat_idx] <= tbl[win_sel - 1'b1][beat_idx];
                    if (beat_idx == LAST_IDX) begin
                        mphase <= M_START;
                        if (win_idx == '0) begin
                            state <= S_OUT;
                        end else begin
                            win_idx <= win_idx - 1'b1;
                            sq_cnt  <= '0;
                            state   <= S_SQR;
                        end
                    end else begin
                        beat_idx <= beat_idx + 1'b1;
                    end
                end

                S_OUT: begin
                    if (mphase == M_START) begin
                        o_pow_if.val <= 1'b1;
                        o_pow_if.sop <= 1'b1;
                        o_pow_if.eop <= (LAST_IDX == '0);
                        o_pow_if.dat <= acc[0];
                        o_pow_if.ctl <= ctl_q;
                        beat_idx     <= '0;
                        mphase       <= M_SEND;
                    end else if (o_pow_if.val && o_pow_if.rdy) begin
                        if (beat_idx == LAST_IDX) begin
                            o_pow_if.val <= 1'b0;
                            o_pow_if.sop <= 1'b0;
                            o_pow_if.eop <= 1'b0;
                            i_pow_if.rdy <= 1'b1;
                            ld_idx       <= '0;
                            mphase       <= M_START;
                            state        <= S_LOAD;
                        end else begin
                            beat_idx     <= op_idx;
                            o_pow_if.sop <= 1'b0;
                            o_pow_if.eop <= (op_idx == LAST_IDX);
                            o_pow_if.dat <= acc[op_idx];
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
